// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer.
// Holds the state encodings, the cycle counter width and a small
// saturating-increment helper for the 8-bit event counters.
package reset_sequencer_pkg;

  localparam int unsigned CNT_W = 17;

  typedef logic [2:0] state_t;

  localparam state_t ST_WAIT_LOCK = 3'd0;
  localparam state_t ST_GT_RST    = 3'd1;
  localparam state_t ST_WAIT_GT   = 3'd2;
  localparam state_t ST_DP_RST    = 3'd3;
  localparam state_t ST_RUN       = 3'd4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/reset_sequencer_syn_block.sv
// syn_block: two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk      destination clock
//   rst      asynchronous active-high reset, clears both flops
//   enable   shift enable
//   data_in  asynchronous input
//   data_out synchronized output, two cycles behind data_in
module syn_block (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic data_in,
  output logic data_out
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b0;
      data_out <= 1'b0;
    end else if (enable) begin
      meta     <= data_in;
      data_out <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: brings up system PLL, transceiver and datapath in order.
// Waits for a stable system PLL lock, pulses the transceiver reset, waits
// for transceiver lock/reset-done (retrying on timeout), holds the datapath
// in reset for a short time, then runs. Loss of system PLL lock anywhere
// after WAIT_LOCK requests a PLL re-reset and restarts the sequence.
// Ports:
//   clk             single system clock
//   g_reset         global reset, asynchronous active-high
//   dcm_locked      system PLL locked (async)
//   gt_pll_locked   transceiver PLL locked (async)
//   gt_reset_done   transceiver reset complete (async)
//   pll_reset_req   one-cycle system PLL re-reset request
//   gt_reset        transceiver reset, active-high
//   datapath_reset  datapath reset, active-high
//   system_ready    high only in RUN
//   gt_retry_count  saturating count of transceiver timeouts
//   lock_loss_count saturating count of system PLL lock losses
//   state_dbg       current state encoding
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned GT_RESET_CYCLES    = 64,
  parameter int unsigned GT_TIMEOUT_CYCLES  = 65536,
  parameter int unsigned DP_RESET_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       g_reset,
  input  logic       dcm_locked,
  input  logic       gt_pll_locked,
  input  logic       gt_reset_done,
  output logic       pll_reset_req,
  output logic       gt_reset,
  output logic       datapath_reset,
  output logic       system_ready,
  output logic [7:0] gt_retry_count,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state_dbg
);

  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GT_RST_LAST  = CNT_W'(GT_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(GT_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DP_RST_LAST  = CNT_W'(DP_RESET_CYCLES - 1);

  logic dcm_locked_s;
  logic gt_pll_locked_s;
  logic gt_reset_done_s;

  syn_block u_sync_dcm (
    .clk      (clk),
    .rst      (g_reset),
    .enable   (1'b1),
    .data_in  (dcm_locked),
    .data_out (dcm_locked_s)
  );

  syn_block u_sync_gt_lock (
    .clk      (clk),
    .rst      (g_reset),
    .enable   (1'b1),
    .data_in  (gt_pll_locked),
    .data_out (gt_pll_locked_s)
  );

  syn_block u_sync_gt_done (
    .clk      (clk),
    .rst      (g_reset),
    .enable   (1'b1),
    .data_in  (gt_reset_done),
    .data_out (gt_reset_done_s)
  );

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             lock_lost;
  logic             gt_timeout;

  // Lock loss overrides every other transition; in WAIT_GT a GT ready
  // seen on the timeout cycle wins over the retry.
  always_comb begin
    state_nxt  = state;
    lock_lost  = 1'b0;
    gt_timeout = 1'b0;
    if (state != ST_WAIT_LOCK && !dcm_locked_s) begin
      state_nxt = ST_WAIT_LOCK;
      lock_lost = 1'b1;
    end else begin
      case (state)
        ST_WAIT_LOCK: if (dcm_locked_s && cnt == LOCK_LAST) state_nxt = ST_GT_RST;
        ST_GT_RST:    if (cnt == GT_RST_LAST) state_nxt = ST_WAIT_GT;
        ST_WAIT_GT: begin
          if (gt_pll_locked_s && gt_reset_done_s) begin
            state_nxt = ST_DP_RST;
          end else if (cnt == TIMEOUT_LAST) begin
            state_nxt  = ST_GT_RST;
            gt_timeout = 1'b1;
          end
        end
        ST_DP_RST:    if (cnt == DP_RST_LAST) state_nxt = ST_RUN;
        ST_RUN:       if (!gt_pll_locked_s) state_nxt = ST_GT_RST;
        default:      state_nxt = ST_WAIT_LOCK;
      endcase
    end
  end

  // Counter clears on any state entry; in WAIT_LOCK it only counts
  // consecutive locked cycles. It is idle in RUN.
  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == ST_WAIT_LOCK) begin
      cnt <= dcm_locked_s ? cnt + 1'b1 : '0;
    end else if (state != ST_RUN) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they switch together with it.
  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      state           <= ST_WAIT_LOCK;
      pll_reset_req   <= 1'b0;
      gt_reset        <= 1'b1;
      datapath_reset  <= 1'b1;
      system_ready    <= 1'b0;
      gt_retry_count  <= '0;
      lock_loss_count <= '0;
    end else begin
      state           <= state_nxt;
      pll_reset_req   <= lock_lost;
      gt_reset        <= (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_GT_RST);
      datapath_reset  <= (state_nxt != ST_RUN);
      system_ready    <= (state_nxt == ST_RUN);
      if (gt_timeout) gt_retry_count <= sat_inc8(gt_retry_count);
      if (lock_lost)  lock_loss_count <= sat_inc8(lock_loss_count);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with small timing parameters.
// Stimulus pushes expected values into a queue; a monitor on the falling
// clock edge pops and compares them against the outputs.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       g_reset;
  logic       dcm_locked;
  logic       gt_pll_locked;
  logic       gt_reset_done;
  logic       pll_reset_req;
  logic       gt_reset;
  logic       datapath_reset;
  logic       system_ready;
  logic [7:0] gt_retry_count;
  logic [7:0] lock_loss_count;
  logic [2:0] state_dbg;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES (8),
    .GT_RESET_CYCLES    (4),
    .GT_TIMEOUT_CYCLES  (32),
    .DP_RESET_CYCLES    (4)
  ) dut (
    .clk             (clk),
    .g_reset         (g_reset),
    .dcm_locked      (dcm_locked),
    .gt_pll_locked   (gt_pll_locked),
    .gt_reset_done   (gt_reset_done),
    .pll_reset_req   (pll_reset_req),
    .gt_reset        (gt_reset),
    .datapath_reset  (datapath_reset),
    .system_ready    (system_ready),
    .gt_retry_count  (gt_retry_count),
    .lock_loss_count (lock_loss_count),
    .state_dbg       (state_dbg)
  );

  always #5 clk = ~clk;

  // Selectors for observed values
  localparam int S_STATE = 0, S_GTR = 1, S_DPR = 2, S_RDY = 3, S_PLL = 4,
                 S_RETRY = 5, S_LOSS = 6, S_MEAS = 7;

  typedef struct {
    string name;
    int    sel;
    int    exp;
    int    tol;
    int    meas;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get(input int sel);
    case (sel)
      S_STATE: return int'(state_dbg);
      S_GTR:   return int'(gt_reset);
      S_DPR:   return int'(datapath_reset);
      S_RDY:   return int'(system_ready);
      S_PLL:   return int'(pll_reset_req);
      S_RETRY: return int'(gt_retry_count);
      S_LOSS:  return int'(lock_loss_count);
      default: return -1;
    endcase
  endfunction

  // Monitor: compares every queued expectation at the falling edge.
  always @(negedge clk) begin
    while (q.size() != 0) begin
      exp_t e;
      int   act;
      int   d;
      e   = q.pop_front();
      act = (e.sel == S_MEAS) ? e.meas : get(e.sel);
      d   = act - e.exp;
      if (d < 0) d = -d;
      checks++;
      if (d > e.tol) begin
        errors++;
        $display("FAIL %s: actual=%0d required=%0d (tol %0d)", e.name, act, e.exp, e.tol);
      end
    end
  end

  task automatic expect_out(input string name, input int sel, input int exp);
    q.push_back('{name, sel, exp, 0, 0});
  endtask

  task automatic expect_meas(input string name, input int meas, input int exp, input int tol);
    q.push_back('{name, S_MEAS, exp, tol, meas});
  endtask

  // Let the monitor drain the queue.
  task automatic sync_mon();
    @(negedge clk);
    #1;
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=timeout required=event within bound", name);
  endtask

  // Poll after each rising edge until output sel equals val; n = edges waited, -1 on expiry.
  task automatic wait_sig(input string name, input int sel, input int val, input int limit,
                          output int n);
    n = 0;
    while (get(sel) != val) begin
      if (n >= limit) begin
        bound_fail(name);
        n = -1;
        return;
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=no finish required=finish");
    checks++;
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, t0, rises;

    g_reset       = 1'b1;
    dcm_locked    = 1'b0;
    gt_pll_locked = 1'b0;
    gt_reset_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    expect_out("rst_state", S_STATE, 0);
    expect_out("rst_gt_reset", S_GTR, 1);
    expect_out("rst_dp_reset", S_DPR, 1);
    expect_out("rst_ready", S_RDY, 0);
    expect_out("rst_pll_req", S_PLL, 0);
    expect_out("rst_retry", S_RETRY, 0);
    expect_out("rst_loss", S_LOSS, 0);
    sync_mon();

    g_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Clean bring-up: 2 sync + 8 lock + 4 GT reset + 2 sync + 4 DP (+1 registered decode)
    dcm_locked = 1'b1;
    t0 = cyc;
    wait_sig("bringup_gt_exit", S_GTR, 0, 60, n);
    expect_meas("bringup_gt_exit_latency", cyc - t0, 14, 0);
    gt_pll_locked = 1'b1;
    gt_reset_done = 1'b1;
    wait_sig("bringup_ready", S_RDY, 1, 60, n);
    expect_meas("bringup_latency", cyc - t0, 20, 1);
    expect_out("bringup_state", S_STATE, 4);
    expect_out("bringup_retry", S_RETRY, 0);
    expect_out("bringup_gt_reset", S_GTR, 0);
    expect_out("bringup_dp_reset", S_DPR, 0);
    sync_mon();

    // Lock loss in RUN
    @(posedge clk);
    #1;
    dcm_locked = 1'b0;
    t0 = cyc;
    wait_sig("lossrun_pll_req", S_PLL, 1, 8, n);
    expect_meas("lossrun_latency", cyc - t0, 2, 1);
    expect_out("lossrun_ready", S_RDY, 0);
    expect_out("lossrun_gt_reset", S_GTR, 1);
    expect_out("lossrun_dp_reset", S_DPR, 1);
    expect_out("lossrun_loss", S_LOSS, 1);
    expect_out("lossrun_state", S_STATE, 0);
    sync_mon();
    @(posedge clk);
    #1;
    expect_out("lossrun_pll_one_cycle", S_PLL, 0);
    expect_out("lossrun_loss_hold", S_LOSS, 1);
    sync_mon();

    // One timeout, then GT ready arriving on the timeout cycle
    gt_pll_locked = 1'b0;
    gt_reset_done = 1'b0;
    dcm_locked    = 1'b1;
    wait_sig("simul_gt_exit1", S_GTR, 0, 60, n);
    wait_sig("simul_timeout1", S_GTR, 1, 60, n);
    expect_meas("simul_wait_gt_len", n, 32, 0);
    expect_out("simul_retry1", S_RETRY, 1);
    expect_out("simul_state_gtrst", S_STATE, 1);
    sync_mon();
    wait_sig("simul_gt_exit2", S_GTR, 0, 20, n);
    expect_meas("simul_gt_rst_len", n, 4, 0);
    repeat (29) @(posedge clk);
    #1;
    gt_pll_locked = 1'b1;
    gt_reset_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_out("simul_still_wait_gt", S_STATE, 2);
    sync_mon();
    @(posedge clk);
    #1;
    expect_out("simul_state_dp_rst", S_STATE, 3);
    expect_out("simul_retry_unchanged", S_RETRY, 1);
    sync_mon();

    // Asynchronous reset during DP_RST, no clock edge before sampling
    @(posedge clk);
    #2;
    g_reset = 1'b1;
    expect_out("midrst_state", S_STATE, 0);
    expect_out("midrst_gt_reset", S_GTR, 1);
    expect_out("midrst_dp_reset", S_DPR, 1);
    expect_out("midrst_ready", S_RDY, 0);
    expect_out("midrst_pll_req", S_PLL, 0);
    expect_out("midrst_retry", S_RETRY, 0);
    expect_out("midrst_loss", S_LOSS, 0);
    sync_mon();
    dcm_locked    = 1'b0;
    gt_pll_locked = 1'b0;
    gt_reset_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    g_reset = 1'b0;

    // Lock glitch: 5 high, 1 low, then high; exit 2 sync + 8 after the last rise
    @(posedge clk);
    #1;
    dcm_locked = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    dcm_locked = 1'b0;
    @(posedge clk);
    #1;
    dcm_locked = 1'b1;
    wait_sig("glitch_exit", S_STATE, 1, 40, n);
    expect_meas("glitch_exit_latency", n, 10, 0);
    expect_out("glitch_loss", S_LOSS, 0);
    sync_mon();

    // GT timeout loop: 4-cycle pulse every 36 cycles, retry count saturates
    wait_sig("tmo_fall0", S_GTR, 0, 20, n);
    wait_sig("tmo_rise1", S_GTR, 1, 60, n);
    wait_sig("tmo_fall1", S_GTR, 0, 20, n);
    wait_sig("tmo_rise2", S_GTR, 1, 60, n2);
    expect_meas("tmo_pulse_width", n, 4, 0);
    expect_meas("tmo_period", n + n2, 36, 0);
    expect_out("tmo_retry2", S_RETRY, 2);
    sync_mon();
    rises = 2;
    while (rises < 300) begin
      wait_sig("tmo_loop_fall", S_GTR, 0, 20, n);
      if (n < 0) break;
      wait_sig("tmo_loop_rise", S_GTR, 1, 60, n);
      if (n < 0) break;
      rises++;
    end
    expect_out("tmo_retry_sat", S_RETRY, 255);
    expect_out("tmo_state", S_STATE, 1);
    sync_mon();
    repeat (40) @(posedge clk);
    #1;
    expect_out("tmo_retry_stays", S_RETRY, 255);
    expect_out("tmo_loss_zero", S_LOSS, 0);
    sync_mon();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
